// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD request master: data width and FSM state encoding.
package gcd_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } state_e;

endpackage

// File: rtl/gcd_op_fifo.sv
// Operand-pair queue: power-of-two depth, first-word-fall-through read, full/empty flags.
module gcd_op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/gcd_master.sv
// Queues operand pairs, issues them one at a time to an external GCD core,
// and presents each result (or a timeout) on a valid/ready output.
module gcd_master
    import gcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_A,
    input  logic [DATA_W-1:0] IN_B,
    output logic              GCD_START,
    output logic [DATA_W-1:0] GCD_A,
    output logic [DATA_W-1:0] GCD_B,
    input  logic              GCD_DONE,
    input  logic [DATA_W-1:0] GCD_Y,
    input  logic              GCD_ERROR,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [DATA_W-1:0] RES_Y,
    output logic              RES_ERR,
    output logic              RES_TIMEOUT,
    output logic              BUSY,
    output logic [7:0]        CNT
);

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   gcd_a_q, gcd_a_d;
    logic [DATA_W-1:0]   gcd_b_q, gcd_b_d;
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W-1:0]   res_y_q, res_y_d;
    logic                res_err_q, res_err_d;
    logic                res_tmo_q, res_tmo_d;
    logic [7:0]          cnt_q, cnt_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [2*DATA_W-1:0] fifo_dout;

    gcd_op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*DATA_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (IN_VALID),
        .din   ({IN_A, IN_B}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_pop = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        gcd_a_d   = gcd_a_q;
        gcd_b_d   = gcd_b_q;
        tmo_cnt_d = tmo_cnt_q;
        res_y_d   = res_y_q;
        res_err_d = res_err_q;
        res_tmo_d = res_tmo_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    {gcd_a_d, gcd_b_d} = fifo_dout;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                // A completion in the final allowed cycle beats the timeout.
                if (GCD_DONE) begin
                    res_y_d   = GCD_Y;
                    res_err_d = GCD_ERROR;
                    res_tmo_d = 1'b0;
                    state_d   = HOLD;
                end else if (tmo_cnt_q == TMO_LIM) begin
                    res_y_d   = '0;
                    res_err_d = 1'b0;
                    res_tmo_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (RES_READY) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            gcd_a_q   <= '0;
            gcd_b_q   <= '0;
            tmo_cnt_q <= '0;
            res_y_q   <= '0;
            res_err_q <= 1'b0;
            res_tmo_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gcd_a_q   <= gcd_a_d;
            gcd_b_q   <= gcd_b_d;
            tmo_cnt_q <= tmo_cnt_d;
            res_y_q   <= res_y_d;
            res_err_q <= res_err_d;
            res_tmo_q <= res_tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign IN_READY    = !fifo_full;
    assign GCD_START   = (state_q == ISSUE);
    assign GCD_A       = gcd_a_q;
    assign GCD_B       = gcd_b_q;
    assign RES_VALID   = (state_q == HOLD);
    assign RES_Y       = res_y_q;
    assign RES_ERR     = res_err_q;
    assign RES_TIMEOUT = res_tmo_q;
    assign BUSY        = (state_q != IDLE);
    assign CNT         = cnt_q;

endmodule
